// File: rtl/hdmi_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hdmi_reset_sequencer_pkg
// Brief    : Shared state encoding and default timing constants.
// Revision : 1.0 - initial release
// ============================================================================
package hdmi_reset_sequencer_pkg;

    localparam int CLKFRQ                = 27_000_000;
    localparam int c_SYNC_STAGES         = 2;
    localparam int c_LOCK_STABLE_CYCLES  = 1024;
    localparam int c_DEBOUNCE_CYCLES     = CLKFRQ / 100;  // 10 ms of board clock
    localparam int c_STAGE_GAP_CYCLES    = 16;
    localparam int c_LOSS_CNT_W          = 8;

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_REL_SERDES = 3'd2,
        ST_REL_PIXEL  = 3'd3,
        ST_REL_AUDIO  = 3'd4,
        ST_RUN        = 3'd5
    } state_t;

    // True once any domain has been released; lock loss is counted only here.
    function automatic logic st_active(state_t s);
        return s inside {ST_REL_SERDES, ST_REL_PIXEL, ST_REL_AUDIO, ST_RUN};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_reset_sequencer_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_reset_sequencer_sync_debounce
// Brief    : Multi-flop synchronizer with optional level debounce.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_reset_sequencer_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 1) begin : g_debounce
            localparam int              c_CW   = $clog2(DEBOUNCE_CYCLES);
            localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

            logic [c_CW-1:0] r_cnt;
            logic            r_db;

            // A new level is accepted only after it has held without interruption.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (w_sync != r_db) begin
                    if (r_cnt == c_LAST) begin
                        r_db  <= w_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign o_level = r_db;
        end else begin : g_bypass
            assign o_level = w_sync;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hdmi_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_reset_sequencer
// Brief    : Releases serdes, pixel and audio resets in order once PLL lock is stable.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_reset_sequencer
    import hdmi_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES        = c_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = c_LOCK_STABLE_CYCLES,
    parameter int DEBOUNCE_CYCLES    = c_DEBOUNCE_CYCLES,
    parameter int STAGE_GAP_CYCLES   = c_STAGE_GAP_CYCLES,
    parameter int LOSS_CNT_W         = c_LOSS_CNT_W
) (
    input  logic                  I_clk,
    input  logic                  I_reset,
    input  logic                  I_pll_lock,
    input  logic                  I_button_n,
    output logic                  O_reset_serdes,
    output logic                  O_reset_pixel,
    output logic                  O_reset_audio,
    output logic                  O_ready,
    output logic [LOSS_CNT_W-1:0] O_lock_loss_cnt,
    output logic [2:0]            O_state
);

    localparam int              c_SW          = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [c_SW-1:0] c_STABLE_LAST = c_SW'(LOCK_STABLE_CYCLES - 1);
    localparam int              c_GW          = (STAGE_GAP_CYCLES > 1) ? $clog2(STAGE_GAP_CYCLES) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST    = c_GW'(STAGE_GAP_CYCLES - 1);

    logic            w_lock_s;
    logic            w_btn_db;
    logic            w_stable;
    logic            w_gap_done;
    logic            w_loss;
    state_t          r_state;
    state_t          w_state_next;
    logic [c_SW-1:0] r_stable_cnt;
    logic [c_GW-1:0] r_gap_cnt;

    hdmi_reset_sequencer_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (1)
    ) u_lock_sync (
        .clk     (I_clk),
        .rst     (I_reset),
        .i_din   (I_pll_lock),
        .o_level (w_lock_s)
    );

    hdmi_reset_sequencer_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_db (
        .clk     (I_clk),
        .rst     (I_reset),
        .i_din   (~I_button_n),
        .o_level (w_btn_db)
    );

    assign w_stable   = w_lock_s && (r_stable_cnt == c_STABLE_LAST);
    assign w_gap_done = (r_gap_cnt == c_GAP_LAST);
    assign w_loss     = st_active(r_state) && !w_lock_s;

    always_comb begin
        w_state_next = r_state;
        if (w_btn_db || w_loss) begin
            w_state_next = ST_HOLD;
        end else begin
            case (r_state)
                ST_HOLD:       w_state_next = ST_WAIT_LOCK;
                ST_WAIT_LOCK:  if (w_stable)   w_state_next = ST_REL_SERDES;
                ST_REL_SERDES: if (w_gap_done) w_state_next = ST_REL_PIXEL;
                ST_REL_PIXEL:  if (w_gap_done) w_state_next = ST_REL_AUDIO;
                ST_REL_AUDIO:  if (w_gap_done) w_state_next = ST_RUN;
                ST_RUN:        w_state_next = ST_RUN;
                default:       w_state_next = ST_HOLD;
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as r_state.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_state         <= ST_HOLD;
            r_stable_cnt    <= '0;
            r_gap_cnt       <= '0;
            O_lock_loss_cnt <= '0;
            O_reset_serdes  <= 1'b1;
            O_reset_pixel   <= 1'b1;
            O_reset_audio   <= 1'b1;
            O_ready         <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (!w_lock_s) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt != c_STABLE_LAST) begin
                r_stable_cnt <= r_stable_cnt + 1'b1;
            end

            if (w_state_next != r_state) begin
                r_gap_cnt <= '0;
            end else if (!w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            if (w_loss && (O_lock_loss_cnt != '1)) begin
                O_lock_loss_cnt <= O_lock_loss_cnt + 1'b1;
            end

            O_reset_serdes <= !st_active(w_state_next);
            O_reset_pixel  <= !(w_state_next inside {ST_REL_PIXEL, ST_REL_AUDIO, ST_RUN});
            O_reset_audio  <= !(w_state_next inside {ST_REL_AUDIO, ST_RUN});
            O_ready        <= (w_state_next == ST_RUN);
        end
    end

    assign O_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_reset_sequencer
// Brief    : Directed self-checking bench for the HDMI reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_reset_sequencer;

    localparam int SYNC_STAGES        = 2;
    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int DEBOUNCE_CYCLES    = 16;
    localparam int STAGE_GAP_CYCLES   = 4;
    localparam int LOSS_CNT_W         = 2;

    // {ready, reset_audio, reset_pixel, reset_serdes}
    localparam logic [3:0] c_HOLD   = 4'b0111;
    localparam logic [3:0] c_SERDES = 4'b0110;
    localparam logic [3:0] c_PIXEL  = 4'b0100;
    localparam logic [3:0] c_AUDIO  = 4'b0000;
    localparam logic [3:0] c_RUN    = 4'b1000;

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b1;
    logic                  pll_lock = 1'b0;
    logic                  button_n = 1'b1;
    logic                  o_rs;
    logic                  o_rp;
    logic                  o_ra;
    logic                  o_ready;
    logic [LOSS_CNT_W-1:0] o_cnt;
    logic [2:0]            o_state;
    logic [3:0]            w_outs;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    assign w_outs = {o_ready, o_ra, o_rp, o_rs};

    always #5 clk = ~clk;

    hdmi_reset_sequencer #(
        .SYNC_STAGES        (SYNC_STAGES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
        .STAGE_GAP_CYCLES   (STAGE_GAP_CYCLES),
        .LOSS_CNT_W         (LOSS_CNT_W)
    ) dut (
        .I_clk           (clk),
        .I_reset         (rst),
        .I_pll_lock      (pll_lock),
        .I_button_n      (button_n),
        .O_reset_serdes  (o_rs),
        .O_reset_pixel   (o_rp),
        .O_reset_audio   (o_ra),
        .O_ready         (o_ready),
        .O_lock_loss_cnt (o_cnt),
        .O_state         (o_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Returns the number of cycles until the output bundle equals tgt, or -1.
    task automatic wait_outs(input logic [3:0] tgt, input int maxc, output int cyc);
        cyc = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (w_outs == tgt) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic walk_to_run(input string tag);
        int c;
        wait_outs(c_PIXEL, 10, c);
        chk({tag, "_pixel_gap"}, c, 4);
        wait_outs(c_AUDIO, 10, c);
        chk({tag, "_audio_gap"}, c, 4);
        wait_outs(c_RUN, 10, c);
        chk({tag, "_ready_gap"}, c, 4);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_outs", w_outs, c_HOLD);
        chk("rst_state", o_state, 0);
        chk("rst_cnt", o_cnt, 0);
        rst = 1'b0;
        tick(2);
        chk("wait_lock_state", o_state, 1);
        chk("wait_lock_outs", w_outs, c_HOLD);

        // Clean power-up
        pll_lock = 1'b1;
        wait_outs(c_SERDES, 20, n);
        chk("t1_serdes_lat", n, 10);
        walk_to_run("t1");
        chk("t1_run_state", o_state, 5);
        chk("t1_cnt", o_cnt, 0);

        // Lock loss in RUN
        pll_lock = 1'b0;
        wait_outs(c_HOLD, 10, n);
        chk("t3_loss_lat", n, 3);
        chk("t3_cnt", o_cnt, 1);
        chk("t3_hold_state", o_state, 0);

        // Relock with a one-cycle glitch while waiting for lock
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        wait_outs(c_SERDES, 30, n);
        chk("t2_glitch_delay", n + 6, 16);
        chk("t2_cnt", o_cnt, 1);
        walk_to_run("t2");

        // Button bounce ignored, then a long press
        for (int i = 0; i < 3; i++) begin
            button_n = 1'b0;
            tick(5);
            button_n = 1'b1;
            tick(3);
        end
        tick(4);
        chk("t4_bounce_state", o_state, 5);
        chk("t4_bounce_outs", w_outs, c_RUN);
        button_n = 1'b0;
        wait_outs(c_HOLD, 20, n);
        chk("t4_press_lat", n, 19);
        tick(1);
        chk("t4_held_state", o_state, 0);
        chk("t4_cnt", o_cnt, 1);
        button_n = 1'b1;
        wait_outs(c_SERDES, 30, n);
        chk("t4_release_lat", n, 20);
        walk_to_run("t4");

        // Repeated losses saturate the counter
        for (int i = 0; i < 4; i++) begin
            pll_lock = 1'b0;
            wait_outs(c_HOLD, 10, n);
            chk("t5_loss_lat", n, 3);
            chk("t5_cnt", o_cnt, (i == 0) ? 2 : 3);
            pll_lock = 1'b1;
            wait_outs(c_SERDES, 20, n);
            chk("t5_relock_lat", n, 10);
        end

        // Asynchronous reset in REL_PIXEL
        wait_outs(c_PIXEL, 10, n);
        chk("t6_pixel_gap", n, 4);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_outs", w_outs, c_HOLD);
        chk("t6_async_state", o_state, 0);
        chk("t6_async_cnt", o_cnt, 0);
        tick(2);
        rst = 1'b0;
        wait_outs(c_SERDES, 20, n);
        chk("t6_restart_lat", n, 10);
        walk_to_run("t6");

        // Lock loss and debounced press in the same cycle count once
        button_n = 1'b0;
        tick(16);
        pll_lock = 1'b0;
        wait_outs(c_HOLD, 10, n);
        chk("t5_both_lat", n, 3);
        chk("t5_both_cnt", o_cnt, 1);
        button_n = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
